// File: rtl/issue_scoreboard.sv
// Issue stage: holds one decoded RV32I instruction, stalls RAW/WAW hazards against a busy-bit
// scoreboard, forwards same-cycle writeback operands, and passes writeback to the register file.
module issue_scoreboard #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            rf_reg_write
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     busy_q, busy_d;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       dec_wr, dec_rd1, dec_rd2;
  logic       wr_rd, rd_rs1, rd_rs2;
  logic       fwd1, fwd2, hazard, fire_out, accept;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign rf_rs1 = instr_q[19:15];
  assign rf_rs2 = instr_q[24:20];

  always_comb begin
    dec_wr  = 1'b0;
    dec_rd1 = 1'b0;
    dec_rd2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: dec_wr = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin dec_wr = 1'b1; dec_rd1 = 1'b1; end
      OP_BRANCH, OP_STORE:      begin dec_rd1 = 1'b1; dec_rd2 = 1'b1; end
      OP_OP:                    begin dec_wr = 1'b1; dec_rd1 = 1'b1; dec_rd2 = 1'b1; end
      default: ;
    endcase
  end

  // x0 is never a hazard source and never becomes busy.
  assign wr_rd  = dec_wr  && (rd != 5'd0);
  assign rd_rs1 = dec_rd1 && (rf_rs1 != 5'd0);
  assign rd_rs2 = dec_rd2 && (rf_rs2 != 5'd0);

  assign fwd1   = wb_valid && (wb_rd == rf_rs1);
  assign fwd2   = wb_valid && (wb_rd == rf_rs2);
  assign hazard = (rd_rs1 && busy_q[rf_rs1] && !fwd1)
               || (rd_rs2 && busy_q[rf_rs2] && !fwd2)
               || (wr_rd && busy_q[rd] && !(wb_valid && (wb_rd == rd)));

  assign out_instr    = instr_q;
  assign out_pc       = pc_q;
  assign out_rs1_data = fwd1 ? wb_data : rf_rs1_data;
  assign out_rs2_data = fwd2 ? wb_data : rf_rs2_data;

  assign rf_rd        = wb_rd;
  assign rf_data      = wb_data;
  assign rf_reg_write = wb_valid && (wb_rd != 5'd0);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    out_valid = (state_q == FULL) && !hazard && !flush;
    fire_out  = out_valid && out_ready;
    in_ready  = !flush && ((state_q == EMPTY) || fire_out);
    accept    = in_valid && in_ready;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (fire_out) begin
      state_d = EMPTY;
    end
  end

  // Set of a newly issued writer wins over a same-cycle clear of the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (fire_out && wr_rd) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed instruction sequence with a queue of expected issues
// checked by an independent monitor, plus direct checks of stall, busy and handshake state.
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_rs1_data, rf_rs2_data;
  logic [31:0] out_instr, out_pc, out_rs1_data, out_rs2_data, wb_data, rf_data;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd, rf_rd;
  logic        wb_valid, rf_reg_write;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf[32];
  int          errors = 0;
  int          checks = 0;

  issue_scoreboard #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rd(rf_rd), .rf_data(rf_data), .rf_reg_write(rf_reg_write)
  );

  always #5 clock = ~clock;

  // Register file model: initial contents rf[i] = i*16.
  assign rf_rs1_data = rf[rf_rs1];
  assign rf_rs2_data = rf[rf_rs2];
  always @(posedge clock) if (rf_reg_write) rf[rf_rd] <= rf_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handshake must match the oldest expected issue.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", out_instr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_instr", out_instr, e.instr);
        chk("issue_pc", out_pc, e.pc);
        chk("issue_rs1_data", out_rs1_data, e.rs1);
        chk("issue_rs2_data", out_rs2_data, e.rs2);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction until accepted (bounded), then drop in_valid.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    logic rdy;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      rdy = in_ready;
      step();
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [31:0] instr, pc, rs1, rs2);
    exp_t e;
    e.instr = instr; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 16);
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", dut.busy_q, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // addi x1,x0,5: rs2 field = 5 -> rf[5]
    push(32'h00500093, 32'h100, 32'h0, 32'h50);
    issue(32'h00500093, 32'h100);
    @(negedge clock);
    chk("addi_out_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("addi_busy1", {31'd0, dut.busy_q[1]}, 32'd1);

    // add x2,x1,x1 stalls until x1 writeback, then takes forwarded operands
    push(32'h00108133, 32'h104, 32'd5, 32'd5);
    issue(32'h00108133, 32'h104);
    @(negedge clock);
    chk("raw_stall0", {31'd0, out_valid}, 32'd0);
    step();
    @(negedge clock);
    chk("raw_stall1", {31'd0, out_valid}, 32'd0);
    step();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    @(negedge clock);
    chk("raw_fwd_valid", {31'd0, out_valid}, 32'd1);
    step();
    wb_valid = 1'b0;
    chk("raw_busy", dut.busy_q, 32'h0000_0004);
    chk("rf_x1_written", rf[1], 32'd5);

    // clear x2, then hold add x4,x2,x3 under backpressure for 3 cycles
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
    step();
    wb_valid = 1'b0;
    chk("wb_clear_x2", dut.busy_q, 32'd0);
    out_ready = 1'b0;
    push(32'h00310233, 32'h108, 32'd7, 32'h30);
    issue(32'h00310233, 32'h108);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_instr", out_instr, 32'h00310233);
      chk("bp_out_rs1", out_rs1_data, 32'd7);
      step();
    end

    // release: fire and accept addi x0,x0,1 in the same cycle
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00100013; in_pc = 32'h10C;
    push(32'h00100013, 32'h10C, 32'h0, 32'd5);
    @(negedge clock);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("x0_no_busy", dut.busy_q, 32'h0000_0010);

    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    @(negedge clock);
    chk("wb_x0_no_write", {31'd0, rf_reg_write}, 32'd0);
    step();
    wb_rd = 5'd4; wb_data = 32'd9;
    @(negedge clock);
    chk("wb_x4_write", {31'd0, rf_reg_write}, 32'd1);
    step();
    wb_valid = 1'b0;
    chk("rf_x0_zero", rf[0], 32'd0);

    // flush a stalled reader of x1
    push(32'h00500093, 32'h110, 32'h0, 32'h50);
    issue(32'h00500093, 32'h110);
    step();
    issue(32'h00108133, 32'h114);
    @(negedge clock);
    chk("pre_flush_stall", {31'd0, out_valid}, 32'd0);
    step();
    flush = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h118;
    @(negedge clock);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", dut.busy_q, 32'd0);
    @(negedge clock);
    chk("flush_empty", {31'd0, out_valid}, 32'd0);
    step();
    push(32'h001082B3, 32'h11C, 32'd5, 32'd5);
    issue(32'h001082B3, 32'h11C);
    @(negedge clock);
    chk("post_flush_issue", {31'd0, out_valid}, 32'd1);
    step();

    // reset mid-hazard: add x6,x5,x5 stalls on x5, then is discarded
    issue(32'h00528333, 32'h120);
    @(negedge clock);
    chk("pre_reset_stall", {31'd0, out_valid}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_reset_busy", dut.busy_q, 32'd0);
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    step(); step();
    chk("pending_issues", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
